data_path_rf: RTL and testbench

- Parametrised successor to the fixed 8-bit two-accumulator datapath of the computer project.
- Provides:
  - a generic-width register file of NUM_REGS entries;
  - PC, MAR, IR and CCR registers;
  - an internal 8-function ALU;
  - two bus multiplexers;
  - a memory-ready handshake that stalls register updates while memory read data is not yet valid.
- Sits between the control-unit FSM, which drives every select/load line, and the memory block.

---
 rtl/data_path_rf.sv | 213 +++++++++++++++++++++
 tb/tb_data_path_rf.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_path_rf.sv
// data_path_rf: parametrised datapath with a general register file, PC, MAR, IR and CCR,
// an 8-function ALU, two bus multiplexers and a memory-ready stall.
//
// Optional feature: define DP_SP_EN to add an ADDR_W-bit stack pointer with SP_Inc/SP_Dec
// ports; Bus1_Sel=11 then selects SP instead of zero.
//
// Ports:
//   Clk, Reset                 rising-edge clock, asynchronous active-high reset
//   from_memory, mem_ready     memory read data and its valid strobe
//   ALU_Sel                    ALU function (add, sub, and, or, xor, inc, dec, pass A)
//   Bus1_Sel, Bus2_Sel         bus source selects
//   Src_A, Src_B, Dst          register indices (ALU operands / Bus1 source, write target)
//   Reg_Load, IR_Load, MAR_Load, PC_Load, PC_Inc, CCR_Load   register update strobes
//   SP_Inc, SP_Dec             stack pointer step (DP_SP_EN only)
//   address                    MAR
//   to_memory                  Bus1
//   IR_out, CCR_Result         IR and registered NZVC
//   stall                      combinational; no register updates this cycle
module data_path_rf #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned NUM_REGS  = 4,
    parameter int unsigned REG_SEL_W = $clog2(NUM_REGS)
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [DATA_W-1:0]    from_memory,
    input  logic                 mem_ready,
    input  logic [2:0]           ALU_Sel,
    input  logic [1:0]           Bus1_Sel,
    input  logic [1:0]           Bus2_Sel,
    input  logic [REG_SEL_W-1:0] Src_A,
    input  logic [REG_SEL_W-1:0] Src_B,
    input  logic [REG_SEL_W-1:0] Dst,
    input  logic                 Reg_Load,
    input  logic                 IR_Load,
    input  logic                 MAR_Load,
    input  logic                 PC_Load,
    input  logic                 PC_Inc,
    input  logic                 CCR_Load,
`ifdef DP_SP_EN
    input  logic                 SP_Inc,
    input  logic                 SP_Dec,
`endif
    output logic [ADDR_W-1:0]    address,
    output logic [DATA_W-1:0]    to_memory,
    output logic [DATA_W-1:0]    IR_out,
    output logic [3:0]           CCR_Result,
    output logic                 stall
);

    localparam int unsigned Msb = DATA_W - 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [3:0]        ccr_q, ccr_d;
    logic [DATA_W-1:0] rf_q [NUM_REGS];
    logic [DATA_W-1:0] rf_d [NUM_REGS];
`ifdef DP_SP_EN
    logic [ADDR_W-1:0] sp_q, sp_d;
`endif

    logic [DATA_W-1:0] op_a, op_b;
    logic [DATA_W-1:0] bus1, bus2;

    // ALU signals
    logic [DATA_W-1:0] alu_y;
    logic [DATA_W-1:0] arith_b;
    logic [DATA_W:0]   arith_ext;
    logic              arith_en, arith_sub;
    logic              alu_c, alu_v;
    logic [3:0]        alu_nzvc;

    assign op_a = rf_q[Src_A];
    assign op_b = rf_q[Src_B];

    always_comb begin
        alu_y     = '0;
        alu_c     = 1'b0;
        alu_v     = 1'b0;
        arith_en  = 1'b0;
        arith_sub = 1'b0;
        arith_b   = op_b;
        arith_ext = '0;
        case (ALU_Sel)
            3'b000: arith_en = 1'b1;
            3'b001: begin
                arith_en  = 1'b1;
                arith_sub = 1'b1;
            end
            3'b010: alu_y = op_a & op_b;
            3'b011: alu_y = op_a | op_b;
            3'b100: alu_y = op_a ^ op_b;
            3'b101: begin
                arith_en = 1'b1;
                arith_b  = DATA_W'(1);
            end
            3'b110: begin
                arith_en  = 1'b1;
                arith_sub = 1'b1;
                arith_b   = DATA_W'(1);
            end
            default: alu_y = op_a;
        endcase
        if (arith_en) begin
            if (arith_sub) begin
                // Top bit of the widened difference is set exactly when A < B (borrow).
                arith_ext = {1'b0, op_a} - {1'b0, arith_b};
                alu_v     = (op_a[Msb] != arith_b[Msb]) && (arith_ext[Msb] != op_a[Msb]);
            end else begin
                arith_ext = {1'b0, op_a} + {1'b0, arith_b};
                alu_v     = (op_a[Msb] == arith_b[Msb]) && (arith_ext[Msb] != op_a[Msb]);
            end
            alu_c = arith_ext[DATA_W];
            alu_y = arith_ext[DATA_W-1:0];
        end
    end

    assign alu_nzvc = {alu_y[Msb], (alu_y == '0), alu_v, alu_c};

    // Bus1: address-width sources are zero-extended.
    always_comb begin
        bus1 = '0;
        case (Bus1_Sel)
            2'b00: bus1[ADDR_W-1:0] = pc_q;
            2'b01: bus1 = op_a;
            2'b10: bus1 = op_b;
            default: begin
`ifdef DP_SP_EN
                bus1[ADDR_W-1:0] = sp_q;
`else
                bus1 = '0;
`endif
            end
        endcase
    end

    always_comb begin
        case (Bus2_Sel)
            2'b00:   bus2 = alu_y;
            2'b01:   bus2 = bus1;
            2'b10:   bus2 = from_memory;
            default: bus2 = '0;
        endcase
    end

    // Only a pending load that depends on memory data can stall.
    assign stall = (Bus2_Sel == 2'b10) && !mem_ready &&
                   (Reg_Load || IR_Load || MAR_Load || PC_Load || PC_Inc || CCR_Load);

    always_comb begin
        pc_d  = pc_q;
        mar_d = mar_q;
        ir_d  = ir_q;
        ccr_d = ccr_q;
        rf_d  = rf_q;
        if (!stall) begin
            if (PC_Load) begin
                pc_d = bus2[ADDR_W-1:0];
            end else if (PC_Inc) begin
                pc_d = pc_q + ADDR_W'(1);
            end
            if (MAR_Load) mar_d = bus2[ADDR_W-1:0];
            if (IR_Load) ir_d = bus2;
            if (CCR_Load) ccr_d = alu_nzvc;
            if (Reg_Load) rf_d[Dst] = bus2;
        end
    end

`ifdef DP_SP_EN
    always_comb begin
        sp_d = sp_q;
        if (!stall) begin
            if (SP_Inc && !SP_Dec) begin
                sp_d = sp_q + ADDR_W'(1);
            end else if (SP_Dec && !SP_Inc) begin
                sp_d = sp_q - ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sp_q <= '1;
        end else begin
            sp_q <= sp_d;
        end
    end
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc_q  <= '0;
            mar_q <= '0;
            ir_q  <= '0;
            ccr_q <= '0;
            rf_q  <= '{default: '0};
        end else begin
            pc_q  <= pc_d;
            mar_q <= mar_d;
            ir_q  <= ir_d;
            ccr_q <= ccr_d;
            rf_q  <= rf_d;
        end
    end

    assign address    = mar_q;
    assign to_memory  = bus1;
    assign IR_out     = ir_q;
    assign CCR_Result = ccr_q;

endmodule

// File: tb/tb_data_path_rf.sv
// Bench for data_path_rf: an 8-bit default instance plus a 16-bit, 8-register instance.
// Stimulus pushes expected values into a scoreboard queue; a monitor on the falling edge
// pops and compares them against the DUT outputs.
module tb_data_path_rf;

    localparam int SelAddr  = 0;
    localparam int SelMem   = 1;
    localparam int SelIr    = 2;
    localparam int SelCcr   = 3;
    localparam int SelStall = 4;
    localparam int SelWMem  = 5;
    localparam int SelWAddr = 6;

    typedef struct {
        string       name;
        int          sel;
        logic [15:0] val;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] from_memory;
    logic       mem_ready;
    logic [2:0] ALU_Sel;
    logic [1:0] Bus1_Sel, Bus2_Sel;
    logic [1:0] Src_A, Src_B, Dst;
    logic       Reg_Load, IR_Load, MAR_Load, PC_Load, PC_Inc, CCR_Load;
`ifdef DP_SP_EN
    logic       SP_Inc, SP_Dec;
`endif
    logic [7:0] address, to_memory, IR_out;
    logic [3:0] CCR_Result;
    logic       stall;

    // Wide instance controls
    logic [15:0] w_from_memory;
    logic [1:0]  w_bus1_sel, w_bus2_sel;
    logic [2:0]  w_src_b, w_dst;
    logic        w_reg_load, w_mar_load, w_pc_load;
    logic [7:0]  w_address;
    logic [15:0] w_to_memory, w_ir;
    logic [3:0]  w_ccr;
    logic        w_stall;

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    data_path_rf dut (
        .Clk(Clk), .Reset(Reset), .from_memory(from_memory), .mem_ready(mem_ready),
        .ALU_Sel(ALU_Sel), .Bus1_Sel(Bus1_Sel), .Bus2_Sel(Bus2_Sel),
        .Src_A(Src_A), .Src_B(Src_B), .Dst(Dst),
        .Reg_Load(Reg_Load), .IR_Load(IR_Load), .MAR_Load(MAR_Load),
        .PC_Load(PC_Load), .PC_Inc(PC_Inc), .CCR_Load(CCR_Load),
`ifdef DP_SP_EN
        .SP_Inc(SP_Inc), .SP_Dec(SP_Dec),
`endif
        .address(address), .to_memory(to_memory), .IR_out(IR_out),
        .CCR_Result(CCR_Result), .stall(stall)
    );

    data_path_rf #(.DATA_W(16), .ADDR_W(8), .NUM_REGS(8)) dut_w (
        .Clk(Clk), .Reset(Reset), .from_memory(w_from_memory), .mem_ready(1'b1),
        .ALU_Sel(3'd0), .Bus1_Sel(w_bus1_sel), .Bus2_Sel(w_bus2_sel),
        .Src_A(3'd0), .Src_B(w_src_b), .Dst(w_dst),
        .Reg_Load(w_reg_load), .IR_Load(1'b0), .MAR_Load(w_mar_load),
        .PC_Load(w_pc_load), .PC_Inc(1'b0), .CCR_Load(1'b0),
`ifdef DP_SP_EN
        .SP_Inc(1'b0), .SP_Dec(1'b0),
`endif
        .address(w_address), .to_memory(w_to_memory), .IR_out(w_ir),
        .CCR_Result(w_ccr), .stall(w_stall)
    );

    function automatic logic [15:0] get_act(input int sel);
        case (sel)
            SelAddr:  return {8'h00, address};
            SelMem:   return {8'h00, to_memory};
            SelIr:    return {8'h00, IR_out};
            SelCcr:   return {12'h000, CCR_Result};
            SelStall: return {15'h0000, stall};
            SelWMem:  return w_to_memory;
            SelWAddr: return {8'h00, w_address};
            default:  return 16'hxxxx;
        endcase
    endfunction

    exp_t        mon_e;
    logic [15:0] mon_act;

    always @(negedge Clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e   = sb.pop_front();
            mon_act = get_act(mon_e.sel);
            checks++;
            if (mon_act !== mon_e.val) begin
                errors++;
                $display("FAIL %s: got %h, want %h", mon_e.name, mon_act, mon_e.val);
            end
        end
    end

    task automatic chk(input string name, input int sel, input logic [15:0] val);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.val  = val;
        e.due  = cyc;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        from_memory = 8'h00;
        mem_ready   = 1'b1;
        ALU_Sel     = 3'd0;
        Bus1_Sel    = 2'd0;
        Bus2_Sel    = 2'd0;
        Src_A       = 2'd0;
        Src_B       = 2'd0;
        Dst         = 2'd0;
        Reg_Load    = 1'b0;
        IR_Load     = 1'b0;
        MAR_Load    = 1'b0;
        PC_Load     = 1'b0;
        PC_Inc      = 1'b0;
        CCR_Load    = 1'b0;
`ifdef DP_SP_EN
        SP_Inc      = 1'b0;
        SP_Dec      = 1'b0;
`endif
        w_from_memory = 16'h0000;
        w_bus1_sel    = 2'd0;
        w_bus2_sel    = 2'd0;
        w_src_b       = 3'd0;
        w_dst         = 3'd0;
        w_reg_load    = 1'b0;
        w_mar_load    = 1'b0;
        w_pc_load     = 1'b0;
    endtask

    task automatic mem_write_reg(input logic [1:0] idx, input logic [7:0] v);
        idle();
        Bus2_Sel    = 2'b10;
        from_memory = v;
        Reg_Load    = 1'b1;
        Dst         = idx;
        tick();
        idle();
    endtask

    task automatic set_pc(input logic [7:0] v);
        idle();
        Bus2_Sel    = 2'b10;
        from_memory = v;
        PC_Load     = 1'b1;
        tick();
        idle();
    endtask

    task automatic peek_reg(input string name, input logic [1:0] idx, input logic [7:0] v);
        idle();
        Bus1_Sel = 2'b01;
        Src_A    = idx;
        chk(name, SelMem, {8'h00, v});
        tick();
    endtask

    task automatic peek_pc(input string name, input logic [7:0] v);
        idle();
        Bus1_Sel = 2'b00;
        chk(name, SelMem, {8'h00, v});
        tick();
    endtask

    // R0=a, R1=b, R2 <= R0 op R1 with CCR_Load, then check R2 and NZVC.
    task automatic alu_check(input string name, input logic [2:0] op, input logic [7:0] a,
                             input logic [7:0] b, input logic [7:0] res,
                             input logic [3:0] nzvc);
        mem_write_reg(2'd0, a);
        mem_write_reg(2'd1, b);
        idle();
        ALU_Sel  = op;
        Src_A    = 2'd0;
        Src_B    = 2'd1;
        Bus2_Sel = 2'b00;
        Reg_Load = 1'b1;
        Dst      = 2'd2;
        CCR_Load = 1'b1;
        tick();
        idle();
        chk({name, " ccr"}, SelCcr, {12'h000, nzvc});
        peek_reg({name, " res"}, 2'd2, res);
    endtask

    initial begin
        idle();
        Reset = 1'b1;
        tick();
        chk("por address", SelAddr, 16'h0000);
        chk("por ir", SelIr, 16'h0000);
        chk("por ccr", SelCcr, 16'h0000);
        chk("por pc", SelMem, 16'h0000);
        tick();
        Reset = 1'b0;

        // Load some state, then reset asynchronously mid-cycle.
        mem_write_reg(2'd1, 8'h5A);
        set_pc(8'h10);
        idle();
        Bus2_Sel = 2'b10; from_memory = 8'h77; IR_Load = 1'b1; tick();
        idle();
        Bus2_Sel = 2'b10; from_memory = 8'h33; MAR_Load = 1'b1; tick();
        idle();
        ALU_Sel = 3'b001; Src_A = 2'd0; Src_B = 2'd1; CCR_Load = 1'b1; tick();
        idle();
        chk("pre-reset ir", SelIr, 16'h0077);
        chk("pre-reset address", SelAddr, 16'h0033);
        chk("pre-reset ccr", SelCcr, 16'h0009);
        peek_reg("pre-reset r1", 2'd1, 8'h5A);
        peek_pc("pre-reset pc", 8'h10);
        idle();
        Bus1_Sel = 2'b01; Src_A = 2'd1;
        Bus2_Sel = 2'b10; from_memory = 8'hEE; Reg_Load = 1'b1; Dst = 2'd3;
        #2 Reset = 1'b1;
        chk("async reset r1", SelMem, 16'h0000);
        chk("async reset address", SelAddr, 16'h0000);
        chk("async reset ir", SelIr, 16'h0000);
        chk("async reset ccr", SelCcr, 16'h0000);
        tick();
        idle();
        chk("reset pc", SelMem, 16'h0000);
        tick();
        Reset = 1'b0;
        peek_reg("discarded write r3", 2'd3, 8'h00);

        // ALU functions and flags
        alu_check("add ovf", 3'b000, 8'h7F, 8'h01, 8'h80, 4'b1010);
        alu_check("add carry", 3'b000, 8'hF0, 8'h3C, 8'h2C, 4'b0001);
        alu_check("sub borrow", 3'b001, 8'h00, 8'h01, 8'hFF, 4'b1001);
        alu_check("sub ovf", 3'b001, 8'h80, 8'h01, 8'h7F, 4'b0010);
        alu_check("and", 3'b010, 8'hF0, 8'h3C, 8'h30, 4'b0000);
        alu_check("or", 3'b011, 8'hF0, 8'h3C, 8'hFC, 4'b1000);
        alu_check("xor", 3'b100, 8'hF0, 8'h3C, 8'hCC, 4'b1000);
        alu_check("inc wrap", 3'b101, 8'hFF, 8'h00, 8'h00, 4'b0101);
        alu_check("dec zero", 3'b110, 8'h01, 8'h00, 8'h00, 4'b0100);
        alu_check("pass", 3'b111, 8'hA5, 8'h00, 8'hA5, 4'b1000);

        // PC increment wrap and load priority
        set_pc(8'hFF);
        idle(); PC_Inc = 1'b1; tick();
        peek_pc("pc inc wrap", 8'h00);
        idle();
        PC_Inc = 1'b1; PC_Load = 1'b1; Bus2_Sel = 2'b10; from_memory = 8'h40;
        tick();
        peek_pc("pc load over inc", 8'h40);

        // Memory stall: IR and PC must hold while mem_ready is low
        idle();
        Bus2_Sel = 2'b10; from_memory = 8'hC3; mem_ready = 1'b0;
        chk("no stall without load", SelStall, 16'h0000);
        tick();
        for (int i = 0; i < 3; i++) begin
            IR_Load = 1'b1; PC_Inc = 1'b1;
            chk("stall high", SelStall, 16'h0001);
            chk("ir held", SelIr, 16'h0000);
            chk("pc held", SelMem, 16'h0040);
            tick();
        end
        mem_ready = 1'b1;
        chk("stall released", SelStall, 16'h0000);
        tick();
        idle();
        chk("ir after ready", SelIr, 16'h00C3);
        peek_pc("pc after ready", 8'h41);

        // Simultaneous loads all capture the same Bus2 value
        idle();
        Bus2_Sel = 2'b10; from_memory = 8'h5B;
        IR_Load = 1'b1; MAR_Load = 1'b1; PC_Load = 1'b1; Reg_Load = 1'b1; Dst = 2'd3;
        tick();
        idle();
        chk("multi ir", SelIr, 16'h005B);
        chk("multi mar", SelAddr, 16'h005B);
        peek_pc("multi pc", 8'h5B);
        peek_reg("multi r3", 2'd3, 8'h5B);

        // Bus2 from Bus1, Bus2 zero
        idle();
        Bus1_Sel = 2'b01; Src_A = 2'd3; Bus2_Sel = 2'b01; Reg_Load = 1'b1; Dst = 2'd0;
        tick();
        peek_reg("bus2 from bus1", 2'd0, 8'h5B);
        idle();
        Bus2_Sel = 2'b11; Reg_Load = 1'b1; Dst = 2'd3;
        tick();
        peek_reg("bus2 zero", 2'd3, 8'h00);

        // Bus1_Sel=11
        idle();
        Bus1_Sel = 2'b11;
`ifdef DP_SP_EN
        chk("sp reset", SelMem, 16'h00FF);
        tick();
        idle(); SP_Dec = 1'b1; tick();
        idle(); Bus1_Sel = 2'b11; chk("sp dec", SelMem, 16'h00FE);
        SP_Inc = 1'b1; SP_Dec = 1'b1; tick();
        idle(); Bus1_Sel = 2'b11; chk("sp both hold", SelMem, 16'h00FE);
        SP_Inc = 1'b1; tick();
        idle(); SP_Inc = 1'b1; tick();
        idle(); Bus1_Sel = 2'b11; chk("sp inc wrap", SelMem, 16'h0000);
        tick();
`else
        chk("bus1 zero", SelMem, 16'h0000);
        tick();
`endif

        // Wide instance: 16-bit data, 8 registers, 8-bit address
        idle();
        w_bus2_sel = 2'b10; w_from_memory = 16'hBEEF; w_reg_load = 1'b1; w_dst = 3'd7;
        tick();
        idle();
        w_bus1_sel = 2'b10; w_src_b = 3'd7;
        chk("wide r7", SelWMem, 16'hBEEF);
        tick();
        idle();
        w_bus2_sel = 2'b10; w_from_memory = 16'h1234; w_mar_load = 1'b1;
        w_pc_load = 1'b1;
        tick();
        idle();
        chk("wide mar low bits", SelWAddr, 16'h0034);
        chk("wide pc zero-ext", SelWMem, 16'h0034);
        tick();

        tick();
        tick();
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard drain: got %0d pending, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
